time_keeper: RTL

//  Time-of-day register for the alarm clock. Counts hh:mm:ss from an internal
//  1 Hz prescaler and applies hour/minute edit requests arriving on the edit

---
 rtl/time_keeper.sv | 129 ++++++++++++
 1 files changed

// File: rtl/time_keeper.sv
// Time-of-day register: hh:mm:ss driven by an internal 1 Hz prescaler, plus hour/minute edit buttons.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat on both edit buttons.
module time_keeper #(
    parameter int TICK_DIV      = 100_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  edit_btns,
    output logic [16:0] time_out,
    output logic        sec_tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("time_keeper: TICK_DIV must be >= 2 and hold/repeat periods >= 1");
    end

    logic [4:0]    hh_reg, hh_next;
    logic [5:0]    mm_reg, mm_next;
    logic [5:0]    ss_reg, ss_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          tick_reg, tick_next;
    logic [1:0]    btn_prev_reg;
    logic [1:0]    edits;

`ifdef AUTO_REPEAT_EN
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
`endif

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_btn
        logic rise;
        assign rise = edit_btns[gi] & ~btn_prev_reg[gi];
`ifdef AUTO_REPEAT_EN
        // Counter restarts at 1 on every generated edit; the first gap is HOLD, later gaps REPEAT.
        logic [HW-1:0] hold_cnt_reg;
        logic          repeating_reg;
        logic          fire;
        assign fire = edit_btns[gi] & ~rise &
                      ((~repeating_reg & (hold_cnt_reg == HW'(HOLD_CYCLES))) |
                       ( repeating_reg & (hold_cnt_reg == HW'(REPEAT_CYCLES))));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hold_cnt_reg  <= '0;
                repeating_reg <= 1'b0;
            end else if (!edit_btns[gi]) begin
                hold_cnt_reg  <= '0;
                repeating_reg <= 1'b0;
            end else if (rise) begin
                hold_cnt_reg  <= HW'(1);
                repeating_reg <= 1'b0;
            end else if (fire) begin
                hold_cnt_reg  <= HW'(1);
                repeating_reg <= 1'b1;
            end else begin
                hold_cnt_reg  <= hold_cnt_reg + HW'(1);
            end
        end
        assign edits[gi] = rise | fire;
`else
        assign edits[gi] = rise;
`endif
    end

    logic [4:0] hh_inc;
    logic [5:0] mm_inc;
    logic [5:0] ss_inc;
    assign hh_inc = (hh_reg >= 5'd23) ? 5'd0 : hh_reg + 5'd1;
    assign mm_inc = (mm_reg >= 6'd59) ? 6'd0 : mm_reg + 6'd1;
    assign ss_inc = (ss_reg >= 6'd59) ? 6'd0 : ss_reg + 6'd1;

    always_comb begin
        hh_next    = hh_reg;
        mm_next    = mm_reg;
        ss_next    = ss_reg;
        presc_next = presc_reg;
        tick_next  = 1'b0;
        if (|edits) begin
            // Edits take priority; a coinciding second advance is dropped.
            presc_next = '0;
            if (edits[1]) hh_next = hh_inc;
            if (edits[0]) begin
                mm_next = mm_inc;
                ss_next = 6'd0;
            end
        end else if (enable) begin
            if (presc_reg == TERM) begin
                presc_next = '0;
                tick_next  = 1'b1;
                ss_next    = ss_inc;
                if (ss_reg >= 6'd59) begin
                    mm_next = mm_inc;
                    if (mm_reg >= 6'd59) hh_next = hh_inc;
                end
            end else begin
                presc_next = presc_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hh_reg       <= '0;
            mm_reg       <= '0;
            ss_reg       <= '0;
            presc_reg    <= '0;
            tick_reg     <= 1'b0;
            btn_prev_reg <= '0;
        end else begin
            hh_reg       <= hh_next;
            mm_reg       <= mm_next;
            ss_reg       <= ss_next;
            presc_reg    <= presc_next;
            tick_reg     <= tick_next;
            btn_prev_reg <= edit_btns;
        end
    end

    assign time_out = {hh_reg, mm_reg, ss_reg};
    assign sec_tick = tick_reg;

endmodule
